// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for an N-digit 7-segment display fed through a 3-bit code decoder.
// Double-buffered digit codes commit only at frame boundaries so a frame is never torn.
module seg7_scan_driver #(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [3*N_DIGITS-1:0]   digits_in,
   input  logic [N_DIGITS-1:0]     blank_mask,
   output logic [2:0]              ABC,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_done
);

   localparam int unsigned IW = $clog2(N_DIGITS);
   localparam int unsigned PW = $clog2(TICK_DIV);

   localparam logic [1:0] OFF  = 2'd0;
   localparam logic [1:0] SHOW = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

   logic [1:0]              state_q, state_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [3*N_DIGITS-1:0]   staging_q, staging_d;
   logic [3*N_DIGITS-1:0]   active_q, active_d;
   logic                    pending_q, pending_d;
   logic [2:0]              abc_q, abc_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic                    fd_q, fd_d;

   logic running, tick, last_slot, commit, lit;

   always_comb begin
      running   = en && (state_q != OFF);
      tick      = running && (presc_q == PRESC_MAX);
      last_slot = tick && (idx_q == IDX_MAX);
      commit    = last_slot && pending_q;

      state_d = state_q;
      if (!en) begin
         state_d = OFF;
      end else begin
         case (state_q)
            OFF:     state_d = SHOW;
            SHOW:    if (tick) state_d = GAP;
            GAP:     state_d = SHOW;
            default: state_d = OFF;
         endcase
      end

      presc_d = presc_q;
      if (running) presc_d = tick ? '0 : presc_q + 1'b1;

      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

      // A load on the commit edge still stages behind the value being committed.
      staging_d = load ? digits_in : staging_q;
      active_d  = commit ? staging_q : active_q;
      pending_d = load | (pending_q & ~commit);

      // en is included so the digit goes dark on the same edge the FSM enters OFF.
      lit   = en && (state_q == SHOW) && !blank_mask[idx_q];
      an_d  = lit ? (N_DIGITS'(1) << idx_q) : '0;
      abc_d = lit ? active_q[3*idx_q +: 3] : 3'b000;
      fd_d  = last_slot;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= OFF;
         presc_q   <= '0;
         idx_q     <= '0;
         staging_q <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         abc_q     <= 3'b000;
         an_q      <= '0;
         fd_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         staging_q <= staging_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         abc_q     <= abc_d;
         an_q      <= an_d;
         fd_q      <= fd_d;
      end
   end

   assign ABC        = abc_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, TICK_DIV=4.
// A table covers reset and the first frame; tasks cover commit, blanking, pause and reset.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [11:0] digits_in;
   logic [3:0]  blank_mask;
   logic [2:0]  abc;
   logic [3:0]  an;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   seg7_scan_driver #(
      .N_DIGITS (4),
      .TICK_DIV (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .digits_in  (digits_in),
      .blank_mask (blank_mask),
      .ABC        (abc),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        en;
      logic        load;
      logic [11:0] digits;
      logic [3:0]  blank;
      logic [3:0]  exp_an;
      logic [2:0]  exp_abc;
      logic        exp_fd;
   } vec_t;

   vec_t vecs [22];
   logic [3:0] an_seq [20] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                               4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Steps until frame_done, requiring every lit slot to show the still-active value.
   task automatic wait_fd(input logic [11:0] old, input string name);
      int n   = 0;
      bit bad = 1'b0;
      int k;
      do begin
         step();
         n++;
         if (an != 4'h0) begin
            k = 0;
            for (int j = 0; j < 4; j++) if (an[j]) k = j;
            if (abc !== old[3*k +: 3]) bad = 1'b1;
         end else if (abc !== 3'b000) begin
            bad = 1'b1;
         end
      end while (frame_done !== 1'b1 && n < 100);
      chk({name, "_fd_seen"}, frame_done, 1);
      chk({name, "_hold_old"}, bad, 0);
   endtask

   // Called on the frame_done sample; walks the following 16-cycle frame.
   task automatic check_frame(input logic [11:0] exp, input logic [3:0] blank, input string name);
      int lit [4] = '{0, 0, 0, 0};
      bit bad_abc = 1'b0;
      bit bad_hot = 1'b0;
      bit bad_fd  = 1'b0;
      for (int s = 1; s <= 16; s++) begin
         step();
         if ($countones(an) > 1) bad_hot = 1'b1;
         if (an == 4'h0 && abc !== 3'b000) bad_abc = 1'b1;
         for (int j = 0; j < 4; j++) begin
            if (an[j]) begin
               lit[j]++;
               if (abc !== exp[3*j +: 3]) bad_abc = 1'b1;
            end
         end
         if (frame_done !== (s == 16)) bad_fd = 1'b1;
      end
      for (int j = 0; j < 4; j++)
         chk($sformatf("%s_lit%0d", name, j), lit[j], blank[j] ? 0 : 3);
      chk({name, "_abc"}, bad_abc, 0);
      chk({name, "_onehot"}, bad_hot, 0);
      chk({name, "_fd_period"}, bad_fd, 0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; load = 1'b0; digits_in = '0; blank_mask = '0;

      vecs[0] = '{rst: 1'b1, en: 1'b1, load: 1'b0, digits: 12'o0, blank: 4'h0,
                  exp_an: 4'h0, exp_abc: 3'b0, exp_fd: 1'b0};
      vecs[1] = vecs[0];
      for (int i = 0; i < 20; i++)
         vecs[i+2] = '{rst: 1'b0, en: 1'b1, load: 1'b0, digits: 12'o0, blank: 4'h0,
                       exp_an: an_seq[i], exp_abc: 3'b0, exp_fd: (i == 16)};

      // Reset with en held high, then the first free-running frame.
      for (int i = 0; i < 22; i++) begin
         rst        = vecs[i].rst;
         en         = vecs[i].en;
         load       = vecs[i].load;
         digits_in  = vecs[i].digits;
         blank_mask = vecs[i].blank;
         step();
         chk($sformatf("vec%0d_an", i), an, vecs[i].exp_an);
         chk($sformatf("vec%0d_abc", i), abc, vecs[i].exp_abc);
         chk($sformatf("vec%0d_fd", i), frame_done, vecs[i].exp_fd);
      end

      // Mid-frame load appears only after the next frame_done.
      digits_in = 12'o7531; load = 1'b1; step(); load = 1'b0;
      wait_fd(12'o0, "pre7531");
      check_frame(12'o7531, 4'h0, "f7531");

      // Two loads in one frame: latest wins.
      step();
      digits_in = 12'o1111; load = 1'b1; step();
      digits_in = 12'o2222; step(); load = 1'b0;
      wait_fd(12'o7531, "pre2222");
      check_frame(12'o2222, 4'h0, "f2222");

      // Load coincident with the commit edge.
      digits_in = 12'o3333; load = 1'b1; step(); load = 1'b0;
      repeat (14) step();
      digits_in = 12'o4444; load = 1'b1; step(); load = 1'b0;
      chk("coincide_fd", frame_done, 1);
      check_frame(12'o3333, 4'h0, "f3333");
      blank_mask = 4'b0100;
      check_frame(12'o4444, 4'b0100, "f4444_blank");

      // Pause mid-digit and resume at the same idx/prescaler.
      step(); step();
      chk("pre_pause_an", an, 4'h1);
      en = 1'b0;
      step(); chk("pause_an0", an, 4'h0); chk("pause_abc0", abc, 3'b000);
      step(); chk("pause_an1", an, 4'h0);
      step(); chk("pause_an2", an, 4'h0);
      en = 1'b1;
      step(); chk("resume_an0", an, 4'h0);
      step(); chk("resume_an1", an, 4'h1); chk("resume_abc1", abc, 3'd4);
      step(); chk("resume_an2", an, 4'h1);
      step(); chk("resume_an3", an, 4'h0);
      step(); chk("resume_an4", an, 4'h2);
      blank_mask = 4'h0;

      // Reset mid-frame with a pending load.
      digits_in = 12'o5555; load = 1'b1; step(); load = 1'b0;
      chk("pre_rst_an", an, 4'h2);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_an", an, 4'h0);
      chk("rst_abc", abc, 3'b000);
      chk("rst_fd", frame_done, 0);
      wait_fd(12'o0, "post_rst");
      check_frame(12'o0, 4'h0, "post_rst_frame");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
